// File: rtl/au_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | au_ctrl_pkg                                                          |
// | Opcodes, controller states and flag bit positions for au_share_ctrl. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package au_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV  = 3'b011,
        OP_RSV4 = 3'b100,
        OP_MOD  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } au_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } au_state_e;

    localparam int c_FLAG_N = 3;
    localparam int c_FLAG_Z = 2;
    localparam int c_FLAG_C = 1;
    localparam int c_FLAG_V = 0;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD};
    endfunction

endpackage
`default_nettype wire

// File: rtl/au_share_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | au_share_ctrl_if                                                     |
// | Two-requester operand bus plus response channel of au_share_ctrl.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface au_share_ctrl_if #(
    parameter int NBIT = 8
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][NBIT-1:0]  req_a;
    logic [1:0][NBIT-1:0]  req_b;
    logic [1:0][2:0]       req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [NBIT-1:0]       rsp_result;
    logic [3:0]            rsp_flags;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/ArithmeticUnit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ArithmeticUnit                                                       |
// | Combinational add/sub/mul/div/mod with N, C, V (Z is left to users). |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module ArithmeticUnit
    import au_ctrl_pkg::*;
#(
    parameter int NBIT = 8
) (
    input  wire logic [NBIT-1:0] i_a,
    input  wire logic [NBIT-1:0] i_b,
    input  wire logic [2:0]      i_op,
    output logic      [NBIT-1:0] o_result,
    output logic                 o_n,
    output logic                 o_c,
    output logic                 o_v
);
    logic [NBIT:0]     w_sum;
    logic [NBIT:0]     w_diff;
    logic [2*NBIT-1:0] w_prod;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_prod = {{NBIT{1'b0}}, i_a} * {{NBIT{1'b0}}, i_b};

    // C is carry for add, borrow for sub, and high-half-nonzero for mul
    always_comb begin
        o_result = '0;
        o_c      = 1'b0;
        o_v      = 1'b0;
        case (au_op_e'(i_op))
            OP_ADD: begin
                o_result = w_sum[NBIT-1:0];
                o_c      = w_sum[NBIT];
                o_v      = (i_a[NBIT-1] == i_b[NBIT-1]) && (w_sum[NBIT-1] != i_a[NBIT-1]);
            end
            OP_SUB: begin
                o_result = w_diff[NBIT-1:0];
                o_c      = w_diff[NBIT];
                o_v      = (i_a[NBIT-1] != i_b[NBIT-1]) && (w_diff[NBIT-1] != i_a[NBIT-1]);
            end
            OP_MUL: begin
                o_result = w_prod[NBIT-1:0];
                o_c      = |w_prod[2*NBIT-1:NBIT];
                o_v      = |w_prod[2*NBIT-1:NBIT];
            end
            OP_DIV:  o_result = (i_b == '0) ? '1  : (i_a / i_b);
            OP_MOD:  o_result = (i_b == '0) ? i_a : (i_a % i_b);
            default: o_result = '0;
        endcase
    end

    assign o_n = o_result[NBIT-1];

endmodule
`default_nettype wire

// File: rtl/au_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | au_rr_arbiter                                                        |
// | Two-way round-robin grant with a single priority pointer bit.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module au_rr_arbiter (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] i_req,
    input  wire logic       i_advance,
    output logic      [1:0] o_grant
);
    logic r_ptr;

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    // Priority passes to whichever requester was not just served
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= 1'b0;
        else if (i_advance)
            r_ptr <= o_grant[0];
    end

endmodule
`default_nettype wire

// File: rtl/au_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | au_share_ctrl                                                        |
// | Shares one ArithmeticUnit between two requesters (IDLE/EXEC/RESP).   |
// | Option: AU_DIV_ZERO_TRAP_EN rejects div/mod by zero with rsp_err.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module au_share_ctrl
    import au_ctrl_pkg::*;
#(
    parameter int NBIT = 8
) (
    input wire logic     clk,
    input wire logic     rst,
    au_share_ctrl_if.slave bus
);
    au_state_e       r_state;
    au_state_e       w_next;
    logic [1:0]      w_grant;
    logic [1:0]      w_ready;
    logic            w_accept;
    logic            w_rsp_valid;
    logic            w_busy;
    logic            w_trap;
    logic            w_reject;

    logic [NBIT-1:0] r_a;
    logic [NBIT-1:0] r_b;
    logic [2:0]      r_op;
    logic            r_id;
    logic [NBIT-1:0] r_result;
    logic [3:0]      r_flags;
    logic            r_err;

    logic [NBIT-1:0] w_au_result;
    logic            w_au_n;
    logic            w_au_c;
    logic            w_au_v;

    au_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (bus.req_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    ArithmeticUnit #(.NBIT(NBIT)) u_au (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_au_result),
        .o_n      (w_au_n),
        .o_c      (w_au_c),
        .o_v      (w_au_v)
    );

    assign w_accept = |(bus.req_valid & w_ready);

`ifdef AU_DIV_ZERO_TRAP_EN
    assign w_trap = ((r_op == OP_DIV) || (r_op == OP_MOD)) && (r_b == '0);
`else
    assign w_trap = 1'b0;
`endif
    assign w_reject = !op_is_legal(r_op) || w_trap;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Grant is withheld while reset is asserted so nothing is accepted then
    always_comb begin
        w_ready     = 2'b00;
        w_rsp_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_ready = rst ? 2'b00 : w_grant;
                w_busy  = 1'b0;
            end
            ST_RESP: w_rsp_valid = 1'b1;
            default: w_busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_id     <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= bus.req_a[w_grant[1]];
                r_b  <= bus.req_b[w_grant[1]];
                r_op <= bus.req_op[w_grant[1]];
                r_id <= w_grant[1];
            end
            if (r_state == ST_EXEC) begin
                if (w_reject) begin
                    r_result <= '0;
                    r_flags  <= '0;
                    r_err    <= 1'b1;
                end else begin
                    r_result          <= w_au_result;
                    r_flags[c_FLAG_N] <= w_au_n;
                    r_flags[c_FLAG_Z] <= (w_au_result == '0);
                    r_flags[c_FLAG_C] <= w_au_c;
                    r_flags[c_FLAG_V] <= w_au_v;
                    r_err             <= 1'b0;
                end
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.busy       = w_busy;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_result = r_result;
    assign bus.rsp_flags  = r_flags;
    assign bus.rsp_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_au_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_au_share_ctrl                                                     |
// | Directed vector table plus arbitration, stall and reset sequences.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_au_share_ctrl;
    localparam int NBIT = 8;

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flags;
        logic       err;
        logic       chk_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[12];
    vec_t v;

    au_share_ctrl_if #(.NBIT(NBIT)) bus ();

    au_share_ctrl #(.NBIT(NBIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_req(input logic id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_op[id] = op;
        bus.req_a[id]  = a;
        bus.req_b[id]  = b;
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [7:0] res,
                             input logic [3:0] flags, input logic err, input logic chk_data);
        chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_id"},    32'(bus.rsp_id),    32'(id));
        chk({tag, "_err"},   32'(bus.rsp_err),   32'(err));
        if (chk_data) begin
            chk({tag, "_result"}, 32'(bus.rsp_result), 32'(res));
            chk({tag, "_flags"},  32'(bus.rsp_flags),  32'(flags));
        end
    endtask

    // Starts and ends at a negedge with the controller idle
    task automatic run_vec(input vec_t t, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        bus.req_valid = 2'b00;
        set_req(t.id, t.op, t.a, t.b);
        bus.req_valid[t.id] = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready), t.id ? 32'd2 : 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk({tag, "_t1_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_t1_busy"},  32'(bus.busy),      32'd1);
        @(negedge clk);
        check_rsp(tag, t.id, t.res, t.flags, t.err, t.chk_data);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'b000, 8'd200, 8'd100, 8'd44,  4'b0010, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 3'b000, 8'd100, 8'd50,  8'd150, 4'b1001, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 3'b001, 8'd5,   8'd5,   8'd0,   4'b0100, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 3'b001, 8'd3,   8'd5,   8'd254, 4'b1010, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 3'b010, 8'd16,  8'd20,  8'd64,  4'b0011, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 3'b011, 8'd100, 8'd7,   8'd14,  4'b0000, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 3'b101, 8'd100, 8'd7,   8'd2,   4'b0000, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 3'b100, 8'd1,   8'd2,   8'd0,   4'b0000, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 3'b110, 8'd9,   8'd9,   8'd0,   4'b0000, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 3'b111, 8'd200, 8'd100, 8'd0,   4'b0000, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 3'b010, 8'd0,   8'd5,   8'd0,   4'b0100, 1'b0, 1'b1};
`ifdef AU_DIV_ZERO_TRAP_EN
        vecs[11] = '{1'b1, 3'b011, 8'd9,   8'd0,   8'd0,   4'b0000, 1'b1, 1'b1};
`else
        vecs[11] = '{1'b1, 3'b011, 8'd9,   8'd0,   8'd0,   4'b0000, 1'b0, 1'b0};
`endif

        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;

        // Reset state, with both requesters pushing during the reset cycle
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  32'(bus.req_ready),  32'd0);
        chk("rst_valid",  32'(bus.rsp_valid),  32'd0);
        chk("rst_busy",   32'(bus.busy),       32'd0);
        chk("rst_id",     32'(bus.rsp_id),     32'd0);
        chk("rst_result", 32'(bus.rsp_result), 32'd0);
        chk("rst_flags",  32'(bus.rsp_flags),  32'd0);
        chk("rst_err",    32'(bus.rsp_err),    32'd0);
        rst           = 1'b0;
        bus.req_valid = 2'b00;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Simultaneous requests: pointer 0 after reset, then requester 1
        do_reset();
        set_req(1'b0, 3'b001, 8'd5, 8'd5);
        set_req(1'b1, 3'b000, 8'd1, 8'd2);
        bus.req_valid = 2'b11;
        #1;
        chk("both_grant0", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b10;
        #1;
        chk("exec_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check_rsp("both_rsp0", 1'b0, 8'd0, 4'b0100, 1'b0, 1'b1);
        chk("resp_ready", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        chk("both_grant1", 32'(bus.req_ready), 32'd2);
        @(posedge clk);
        @(negedge clk);
        set_req(1'b0, 3'b000, 8'd7, 8'd8);
        bus.req_valid = 2'b01;
        @(negedge clk);
        check_rsp("both_rsp1", 1'b1, 8'd3, 4'b0000, 1'b0, 1'b1);

        // Consumer stalls; response must hold and the waiting requester sits out
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_rsp("stall", 1'b1, 8'd3, 4'b0000, 1'b0, 1'b1);
            chk("stall_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_busy",  32'(bus.busy),      32'd1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        chk("waiter_grant", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        check_rsp("waiter_rsp", 1'b0, 8'd15, 4'b0000, 1'b0, 1'b1);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        // Illegal opcode, then reset in EXEC of an add from requester 0
        do_reset();
        v = '{1'b0, 3'b111, 8'd3, 8'd4, 8'd0, 4'b0000, 1'b1, 1'b1};
        run_vec(v, 100);
        set_req(1'b0, 3'b000, 8'd1, 8'd1);
        bus.req_valid = 2'b01;
        #1;
        chk("inflight_grant", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        chk("inflight_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("discard_valid", 32'(bus.rsp_valid), 32'd0);
            chk("discard_busy",  32'(bus.busy),      32'd0);
            @(negedge clk);
        end
        bus.req_valid = 2'b11;
        #1;
        chk("post_rst_grant", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/au_share_ctrl.md
AU_SHARE_CTRL -- requirements
Module: au_share_ctrl

Interface
REQ-001 Parameter: NBIT, default 8, operand and result width in bits.
REQ-002 clk  input  1  single clock, rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 req_ready  output  2  per-requester accept; request i accepted when req_valid[i] && req_ready[i].
REQ-006 req_a  input  2xNBIT  operand A per requester.
REQ-007 req_b  input  2xNBIT  operand B per requester.
REQ-008 req_op  input  2x3  opcode per requester (000 add, 001 sub, 010 mul, 011 div, 101 mod).
REQ-009 rsp_valid  output  1  response valid.
REQ-010 rsp_ready  input  1  response consumer ready.
REQ-011 rsp_id  output  1  index of the requester that owns the response.
REQ-012 rsp_result  output  NBIT  registered operation result.
REQ-013 rsp_flags  output  4  registered {N,Z,C,V}.
REQ-014 rsp_err  output  1  operation rejected (unsupported opcode or trapped condition).
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-017 IDLE: req_ready SHALL be one-hot on the granted requester, or zero if no requester is valid. On acceptance: latch A, B, op and id; go to EXEC.
REQ-018 EXEC: result, N, C and V from the single arithmetic unit instance SHALL be captured into response registers; go to RESP. One cycle only.
REQ-019 RESP: rsp_valid=1. rsp_id, rsp_result, rsp_flags and rsp_err SHALL stay stable until rsp_valid && rsp_ready, then go to IDLE.
REQ-020 Latency: acceptance in cycle t gives rsp_valid high in cycle t+2. Peak throughput is one operation per 3 cycles.
REQ-021 req_ready SHALL be 2'b00 in EXEC and RESP.
REQ-022 Arbitration is round-robin with a 1-bit priority pointer.
  - A lone valid requester is granted.
  - If both are valid, the pointer's requester is granted.
  - After each acceptance, the pointer moves to the other requester.
REQ-023 Z SHALL be computed by this block as (captured result == 0), for every supported opcode.
REQ-024 Opcodes 100, 110 and 111 SHALL produce rsp_err=1, rsp_result=0 and rsp_flags=0, with normal latency.
REQ-025 A request arriving while busy SHALL wait. This block adds no queuing; requesters hold their inputs until accepted.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL behave as follows:
  - state=IDLE, priority pointer=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0, busy=0.
  - req_ready=0 during the reset cycle.
REQ-027 Reset in EXEC or RESP SHALL discard the in-flight operation; no response is ever emitted for it.

Configuration
REQ-028 Macro AU_DIV_ZERO_TRAP_EN:
  - Defined: op 011 or 101 with B==0 SHALL give rsp_err=1, rsp_result=0, rsp_flags=0, with normal latency.
  - Undefined: such operations pass through unmodified with rsp_err=0, and the result is whatever the arithmetic unit produces.

Structure
REQ-029 Package au_ctrl_pkg SHALL hold:
  - opcode enum/localparams;
  - FSM state enum;
  - flag bit indices (N=3, Z=2, C=1, V=0).
REQ-030 Sub-module au_rr_arbiter SHALL implement the 2-way round-robin grant and pointer update.
REQ-031 au_share_ctrl SHALL contain exactly one ArithmeticUnit #(NBIT) instance, driven from the latched operands.

Verification (NBIT=8)
REQ-032 After reset, requester 0 sends add A=200, B=100 -> rsp_valid at accept+2, id=0, result=44, C=1, Z=0, err=0.
REQ-033 Both valid in the same cycle after reset; r0 sub 5-5, r1 add 1+2 -> first response id=0, result=0, Z=1; then id=1, result=3. Grant order 0 then 1.
REQ-034 rsp_ready held low for 4 cycles in RESP -> rsp_valid and all rsp_* fields stable; req_ready=00 throughout; busy=1.
REQ-035 div A=9, B=0 -> with AU_DIV_ZERO_TRAP_EN: err=1, result=0, flags=0. Without it: err=0.
REQ-036 Opcode 111 -> err=1, result=0, flags=0 at accept+2. rst pulsed during EXEC of a following add -> rsp_valid stays 0, pointer=0, next grant goes to requester 0.
